// File: rtl/io_out_buffer.sv
// Output buffer between the CPU OUT strobe and the peripheral bus.
// Captures {addr, data} pairs into an output stage fronted by an in-order FIFO with drop counting.
module io_out_buffer #(
    parameter int DEPTH = 8,
    parameter int AW    = 16,
    parameter int DW    = 16,
    parameter int CW    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [AW-1:0]            cpu_base,
    input  logic [DW-1:0]            cpu_data,
    input  logic                     cpu_flag,
    output logic                     busy,
    output logic [AW-1:0]            io_addr,
    output logic [DW-1:0]            io_data,
    output logic                     io_valid,
    input  logic                     io_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CW-1:0]            drop_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [AW-1:0] mem_addr [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic pop;
    logic os_free;
    logic direct;
    logic move;
    logic append;
    logic drop;
    logic [LW-1:0] level_next;

    always_comb begin
        pop     = io_valid && io_ready;
        os_free = !io_valid || pop;
        move    = os_free && (level != '0);
        direct  = cpu_flag && (level == '0) && os_free;
        // When full, a same-edge head move frees exactly the slot the append needs.
        append  = cpu_flag && !direct && ((level < FULL) || os_free);
        drop    = cpu_flag && !direct && !append;
        level_next = level;
        if (append && !move) begin
            level_next = level + 1'b1;
        end else if (move && !append) begin
            level_next = level - 1'b1;
        end
    end

    assign busy = (level == FULL);

    always_ff @(posedge clk) begin
        if (append) begin
            mem_addr[wr_ptr] <= cpu_base;
            mem_data[wr_ptr] <= cpu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            io_valid   <= 1'b0;
            io_addr    <= '0;
            io_data    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            drop_count <= '0;
        end else begin
            if (append) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (move) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (direct) begin
                io_addr  <= cpu_base;
                io_data  <= cpu_data;
                io_valid <= 1'b1;
            end else if (move) begin
                io_addr  <= mem_addr[rd_ptr];
                io_data  <= mem_data[rd_ptr];
                io_valid <= 1'b1;
            end else if (pop) begin
                io_valid <= 1'b0;
            end
            level <= level_next;
            if (drop && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_io_out_buffer.sv
// Directed bench for io_out_buffer: a vector table for the basic flow plus
// hand-written sequences for overflow, simultaneous push/pop, reset mid-stall and saturation.
module tb_io_out_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_base;
    logic [15:0] cpu_data;
    logic        cpu_flag;
    logic        busy;
    logic [15:0] io_addr;
    logic [15:0] io_data;
    logic        io_valid;
    logic        io_ready;
    logic [3:0]  level;
    logic [7:0]  drop_count;

    int n_vec  = 0;
    int n_fail = 0;

    io_out_buffer #(.DEPTH(8), .AW(16), .DW(16), .CW(8)) dut (
        .clk(clk), .reset(reset), .cpu_base(cpu_base), .cpu_data(cpu_data),
        .cpu_flag(cpu_flag), .busy(busy), .io_addr(io_addr), .io_data(io_data),
        .io_valid(io_valid), .io_ready(io_ready), .level(level), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        flag;
        logic [15:0] base;
        logic [15:0] data;
        logic        rdy;
        logic        ev;
        logic [15:0] ea;
        logic [15:0] ed;
        logic [3:0]  el;
        logic        eb;
        logic [7:0]  edr;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic rst, input logic flag, input logic [15:0] base,
                                input logic [15:0] data, input logic rdy, input logic ev,
                                input logic [15:0] ea, input logic [15:0] ed,
                                input logic [3:0] el, input logic eb, input logic [7:0] edr);
        vec_t v;
        v.rst = rst; v.flag = flag; v.base = base; v.data = data; v.rdy = rdy;
        v.ev = ev; v.ea = ea; v.ed = ed; v.el = el; v.eb = eb; v.edr = edr;
        return v;
    endfunction

    // Drive at the falling edge, let one rising edge happen, then sample 1 ns later.
    task automatic step(input logic r, input logic f, input logic [15:0] b,
                        input logic [15:0] d, input logic rdy);
        @(negedge clk);
        reset = r; cpu_flag = f; cpu_base = b; cpu_data = d; io_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic ev, input logic [15:0] ea,
                           input logic [15:0] ed, input logic [3:0] el, input logic eb,
                           input logic [7:0] edr, input logic chk_ad);
        chk({name, ".valid"}, 32'(io_valid), 32'(ev));
        if (chk_ad) begin
            chk({name, ".addr"}, 32'(io_addr), 32'(ea));
            chk({name, ".data"}, 32'(io_data), 32'(ed));
        end
        chk({name, ".level"}, 32'(level), 32'(el));
        chk({name, ".busy"}, 32'(busy), 32'(eb));
        chk({name, ".drop"}, 32'(drop_count), 32'(edr));
    endtask

    initial begin
        reset = 1'b1; cpu_flag = 1'b0; cpu_base = '0; cpu_data = '0; io_ready = 1'b0;

        //                rst flag base     data     rdy ev  addr     data     lvl busy drop
        vecs[0]  = mk(1, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0, 0);
        vecs[1]  = mk(0, 1, 16'h0001, 16'h000A, 1, 1, 16'h0001, 16'h000A, 0, 0, 0);
        vecs[2]  = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0, 0);
        vecs[3]  = mk(0, 1, 16'h0001, 16'h0011, 0, 1, 16'h0001, 16'h0011, 0, 0, 0);
        vecs[4]  = mk(0, 1, 16'h0002, 16'h0022, 0, 1, 16'h0001, 16'h0011, 1, 0, 0);
        vecs[5]  = mk(0, 1, 16'h0003, 16'h0033, 0, 1, 16'h0001, 16'h0011, 2, 0, 0);
        vecs[6]  = mk(0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0002, 16'h0022, 1, 0, 0);
        vecs[7]  = mk(0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0003, 16'h0033, 0, 0, 0);
        vecs[8]  = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0, 0);
        vecs[9]  = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0, 0);
        vecs[10] = mk(0, 1, 16'h0004, 16'h0044, 1, 1, 16'h0004, 16'h0044, 0, 0, 0);
        vecs[11] = mk(0, 1, 16'h0005, 16'h0055, 1, 1, 16'h0005, 16'h0055, 0, 0, 0);
        vecs[12] = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0, 0);

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].rst, vecs[i].flag, vecs[i].base, vecs[i].data, vecs[i].rdy);
            chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ea, vecs[i].ed,
                    vecs[i].el, vecs[i].eb, vecs[i].edr, vecs[i].ev || vecs[i].rst);
        end

        // Fill OS plus all 8 FIFO slots, then overflow twice.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 1, 16'h0010 + 16'(i), 16'h0100 + 16'(i), 0);
        chk_all("fill", 1, 16'h0010, 16'h0100, 8, 1, 0, 1);
        step(0, 1, 16'h00EE, 16'h0EEE, 0);
        step(0, 1, 16'h00EF, 16'h0EEF, 0);
        chk_all("overflow", 1, 16'h0010, 16'h0100, 8, 1, 2, 1);

        // Full FIFO, strobe and ready on the same edge: both accepted.
        step(0, 1, 16'h0030, 16'h0300, 1);
        chk_all("push_pop_full", 1, 16'h0011, 16'h0101, 8, 1, 2, 1);

        // Drain: the dropped pairs must never appear, order must be preserved.
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 0, 0, 1);
            chk_all($sformatf("drain%0d", i), 1, 16'h0012 + 16'(i), 16'h0102 + 16'(i),
                    4'(7 - i), 0, 2, 1);
        end
        step(0, 0, 0, 0, 1);
        chk_all("drain_last", 1, 16'h0030, 16'h0300, 0, 0, 2, 1);
        step(0, 0, 0, 0, 1);
        chk_all("drain_empty", 0, 0, 0, 0, 0, 2, 0);

        // Reset while stalled with io_valid=1 and level=5.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 16'h0040 + 16'(i), 16'h0400 + 16'(i), 0);
        chk_all("stall5", 1, 16'h0040, 16'h0400, 5, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        chk_all("reset_mid", 0, 16'h0000, 16'h0000, 0, 0, 0, 1);
        step(0, 1, 16'h0077, 16'h0777, 0);
        chk_all("post_reset", 1, 16'h0077, 16'h0777, 0, 0, 0, 1);

        // Saturate the drop counter.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 1, 16'h0050 + 16'(i), 16'h0500 + 16'(i), 0);
        for (int i = 0; i < 254; i++) step(0, 1, 16'hDEAD, 16'hBEEF, 0);
        chk("drop254", 32'(drop_count), 32'd254);
        step(0, 1, 16'hDEAD, 16'hBEEF, 0);
        chk("drop255", 32'(drop_count), 32'd255);
        for (int i = 0; i < 3; i++) step(0, 1, 16'hDEAD, 16'hBEEF, 0);
        chk_all("drop_sat", 1, 16'h0050, 16'h0500, 8, 1, 255, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
